// File: rtl/fp_add_seq.sv
// fp_add_seq: issues one operation at a time to a non-pipelined FP adder and queues its results
module fp_add_seq #(
  parameter int W     = 32,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  input  logic [2:0]   req_rm,
  output logic [W-1:0] add_in1,
  output logic [W-1:0] add_in2,
  output logic [2:0]   add_round_m,
  input  logic [W-1:0] add_out,
  input  logic         add_ov,
  input  logic         add_un,
  input  logic         add_inv,
  input  logic         add_inexact,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [4:0]   rsp_flags,
  output logic [4:0]   fflags,
  input  logic         fflags_clr,
  output logic         busy
);
  localparam int AW  = $clog2(DEPTH);
  localparam int AW1 = AW + 1;
  localparam int CW  = $clog2(LAT) + 1;
  localparam logic [1:0] s_idle = 2'd0, s_wait = 2'd1, s_capt = 2'd2;
  localparam logic [AW:0] full = AW1'(DEPTH);
  localparam logic [AW:0] almost = AW1'(DEPTH - 1);
  localparam logic [CW-1:0] last = CW'(LAT - 1);
  logic [1:0]    state;
  logic [CW-1:0] wcnt;
  logic [W+4:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;
  logic          accept, push, pop;
  logic [4:0]    push_flags;
  // a pop is not credited to req_ready in the same cycle, keeping ready off the rsp path
  always_comb begin
    req_ready  = (state == s_idle && fifo_cnt < full) || (state == s_capt && fifo_cnt < almost);
    accept     = req_valid && req_ready;
    push       = state == s_capt;
    rsp_valid  = fifo_cnt != '0;
    pop        = rsp_valid && rsp_ready;
    push_flags = {add_inv, 1'b0, add_ov, add_un, add_inexact};
    {rsp_data, rsp_flags} = mem[rd_ptr];
    busy       = state != s_idle || rsp_valid;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= s_idle;
      wcnt        <= '0;
      add_in1     <= '0;
      add_in2     <= '0;
      add_round_m <= '0;
    end else if (accept) begin
      add_in1     <= req_a;
      add_in2     <= req_b;
      add_round_m <= req_rm;
      wcnt        <= '0;
      state       <= s_wait;
    end else if (state == s_wait) begin
      if (wcnt == last) state <= s_capt;
      else wcnt <= wcnt + 1'b1;
    end else if (state == s_capt) begin
      state <= s_idle;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      fflags   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {add_out, push_flags};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (push || fflags_clr) fflags <= (fflags_clr ? 5'b0 : fflags) | (push ? push_flags : 5'b0);
    end
  end
endmodule

// File: tb/tb_fp_add_seq.sv
// tb_fp_add_seq: directed and random checks of the adder sequencer against a queue-based reference
module tb_fp_add_seq;
  localparam int W = 32, LAT = 2, DEPTH = 4;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready;
  logic [W-1:0] req_a = 0, req_b = 0;
  logic [2:0] req_rm = 0;
  logic [W-1:0] add_in1, add_in2, add_out;
  logic [2:0] add_round_m;
  logic add_ov, add_un, add_inv, add_inexact;
  logic rsp_valid, rsp_ready = 1;
  logic [W-1:0] rsp_data;
  logic [4:0] rsp_flags, fflags;
  logic fflags_clr = 0, busy;
  int nvec = 0, nerr = 0;

  fp_add_seq #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rm(req_rm),
    .add_in1(add_in1), .add_in2(add_in2), .add_round_m(add_round_m),
    .add_out(add_out), .add_ov(add_ov), .add_un(add_un), .add_inv(add_inv),
    .add_inexact(add_inexact), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .fflags(fflags),
    .fflags_clr(fflags_clr), .busy(busy));

  always #5 clk = ~clk;

  // stand-in adder: known FP cases exact, other operands give arbitrary but deterministic results
  function automatic logic [36:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    if (a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 5'b00000};
    if (a == 32'h3F800000 && b == 32'h3F800000) return {32'h40000000, 5'b00000};
    if (a == 32'h7F800000 && b == 32'hFF800000) return {32'h7FC00000, 5'b10000};
    if (a == 32'h3F800000 && b == 32'h30800000) return {32'h3F800000, 5'b00001};
    return {a + b + {29'b0, rm}, a[0] ^ b[1], 1'b0, a[2] & b[3], a[4] ^ b[5], a[6] | b[7]};
  endfunction

  logic [36:0] s1, s2;
  always @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ref_add(add_in1, add_in2, add_round_m);
      s2 <= s1;
    end
  assign add_out = s2[36:5];
  assign add_inv = s2[4];
  assign add_ov = s2[2];
  assign add_un = s2[1];
  assign add_inexact = s2[0];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    int n = 0;
    req_a = a; req_b = b; req_rm = rm; req_valid = 1;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("send_timeout", n < 50, 1);
    tick();
    req_valid = 0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    chk("rsp_timeout", n < 50, 1);
  endtask

  // reference: pending ops count down to their push, then live in a response queue
  typedef struct packed {logic [36:0] r; int rem;} pend_t;
  pend_t pend[$];
  logic [36:0] fq[$];
  logic [4:0] ff_m;
  logic [31:0] m_in1, m_in2;
  logic [2:0] m_rm;
  bit p_pop, p_clr;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      pend.delete(); fq.delete();
      ff_m = 0; p_pop = 0; p_clr = 0; m_in1 = 0; m_in2 = 0; m_rm = 0;
    end else begin
      if (p_pop && fq.size() > 0) void'(fq.pop_front());
      if (p_clr) ff_m = 0;
      foreach (pend[i]) pend[i].rem = pend[i].rem - 1;
      if (pend.size() > 0 && pend[0].rem == 0) begin
        chk("fifo_overflow", fq.size() < DEPTH, 1);
        fq.push_back(pend[0].r);
        ff_m = ff_m | pend[0].r[4:0];
        void'(pend.pop_front());
      end
      chk("m_rsp_valid", rsp_valid, fq.size() != 0);
      if (fq.size() != 0) begin
        chk("m_rsp_data", rsp_data, fq[0][36:5]);
        chk("m_rsp_flags", rsp_flags, fq[0][4:0]);
      end
      chk("m_fflags", fflags, ff_m);
      chk("m_busy", busy, pend.size() != 0 || fq.size() != 0);
      chk("m_req_ready", req_ready, (pend.size() == 0 && fq.size() < DEPTH) ||
          (pend.size() == 1 && pend[0].rem == 1 && fq.size() < DEPTH - 1));
      chk("m_add_in", {add_round_m, add_in2, add_in1}, {m_rm, m_in2, m_in1});
      p_pop = rsp_valid && rsp_ready;
      p_clr = fflags_clr;
      if (req_valid && req_ready) begin
        pend.push_back('{ref_add(req_a, req_b, req_rm), LAT + 2});
        m_in1 = req_a; m_in2 = req_b; m_rm = req_rm;
      end
    end
  end

  initial begin
    int n, acc, first, second;
    logic [31:0] a0;
    tick(); tick();
    chk("rst_in", {add_round_m, add_in2, add_in1}, 0);
    chk("rst_rsp", {rsp_valid, rsp_data, rsp_flags}, 0);
    chk("rst_ff_busy", {fflags, busy}, 0);
    rst = 0;
    tick();
    // 1.0 + 2.0: operands held for the adder latency, response after LAT+1 cycles
    req_a = 32'h3F800000; req_b = 32'h40000000; req_rm = 0; req_valid = 1;
    chk("t1_ready", req_ready, 1);
    tick();
    req_valid = 0;
    for (int i = 0; i < LAT + 1; i++) begin
      chk("t1_hold", {add_in1, add_in2}, {32'h3F800000, 32'h40000000});
      chk("t1_early", rsp_valid, 0);
      tick();
    end
    chk("t1_valid", rsp_valid, 1);
    chk("t1_data", rsp_data, 32'h40400000);
    chk("t1_flags", rsp_flags, 5'b00000);
    tick();
    // inf + -inf is invalid and sticks in fflags across a clean op
    send(32'h7F800000, 32'hFF800000, 0);
    wait_rsp(n);
    chk("t2_nan", rsp_data, 32'h7FC00000);
    chk("t2_flags", rsp_flags, 5'b10000);
    tick();
    send(32'h3F800000, 32'h3F800000, 0);
    wait_rsp(n);
    chk("t2_two", rsp_data, 32'h40000000);
    chk("t2_flags2", rsp_flags, 5'b00000);
    chk("t2_sticky", fflags, 5'b10000);
    tick();
    // clear coinciding with a push keeps only the new flags
    send(32'h3F800000, 32'h30800000, 0);
    tick(); tick();
    fflags_clr = 1;
    tick();
    fflags_clr = 0;
    chk("t3_data", rsp_data, 32'h3F800000);
    chk("t3_flags", rsp_flags, 5'b00001);
    chk("t3_fflags", fflags, 5'b00001);
    tick();
    fflags_clr = 1;
    tick();
    fflags_clr = 0;
    chk("t3_clr", fflags, 5'b00000);
    // back-pressure: four ops fill the FIFO
    rsp_ready = 0; req_valid = 1;
    req_a = $urandom; req_b = $urandom; req_rm = 3'($urandom);
    acc = 0; n = 0; first = 0; second = 0;
    while (acc < 4 && n < 60) begin
      automatic logic r = req_ready;
      tick(); n++;
      if (r) begin
        acc++;
        if (acc == 1) first = n;
        if (acc == 2) second = n;
        req_a = $urandom; req_b = $urandom; req_rm = 3'($urandom);
      end
    end
    req_valid = 0;
    chk("t4_accepts", acc, 4);
    chk("t4_gap", second - first, LAT + 1);
    for (int i = 0; i < 6; i++) begin
      chk("t4_full", req_ready, 0);
      tick();
    end
    chk("t4_count", {rsp_valid, busy}, 2'b11);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("t4_ready_back", req_ready, 1);
    rsp_ready = 1;
    n = 0;
    while (rsp_valid && n < 10) begin tick(); n++; end
    chk("t4_drain", n, 3);
    // reset while waiting discards the op
    a0 = $urandom;
    send(a0, 32'h12345678, 3'd5);
    #1 rst = 1;
    #1;
    chk("t5_in", {add_round_m, add_in2, add_in1}, 0);
    chk("t5_out", {rsp_valid, busy, fflags}, 0);
    tick(); tick();
    rst = 0;
    for (int i = 0; i < 6; i++) begin
      chk("t5_quiet", rsp_valid, 0);
      tick();
    end
    send(32'h3F800000, 32'h40000000, 0);
    wait_rsp(n);
    chk("t5_lat", n, LAT + 1);
    chk("t5_data", rsp_data, 32'h40400000);
    tick();
    // push and pop on the same edge with two entries queued
    rsp_ready = 0;
    send($urandom, $urandom, 3'($urandom));
    send($urandom, $urandom, 3'($urandom));
    tick(); tick(); tick();
    send($urandom, $urandom, 3'($urandom));
    tick(); tick();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    rsp_ready = 1;
    n = 0;
    while (rsp_valid && n < 10) begin tick(); n++; end
    chk("t6_count", n, 2);
    // random traffic wraps the pointers many times
    for (int i = 0; i < 400; i++) begin
      req_valid = 1'($urandom);
      req_a = $urandom; req_b = $urandom; req_rm = 3'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      fflags_clr = ($urandom % 10) == 0;
      tick();
    end
    req_valid = 0; rsp_ready = 1; fflags_clr = 0;
    for (int i = 0; i < 12; i++) tick();
    chk("end_idle", {busy, rsp_valid}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/fp_add_seq.md
Name: fp_add_seq

Overview:
Issue/retire sequencer placed directly upstream of the single-precision FP adder. It accepts operand requests on a valid/ready interface and drives the adder's operand and rounding-mode inputs. It holds those inputs stable for the adder's full latency, because the adder is not internally pipelined for overlapping operations. It then captures the adder's result and exception flags into a response FIFO and keeps a sticky exception-flag register (fflags).

Parameters:
W, 32, operand/result width
LAT, 2, adder latency in cycles (operands stable -> result valid at adder output)
DEPTH, 4, response FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst  input  1  asynchronous reset, active-high
req_valid  input  1  request valid
req_ready  output  1  request accepted when req_valid&&req_ready at clk edge
req_a  input  W  operand 1
req_b  input  W  operand 2
req_rm  input  3  rounding mode, passed through unchanged
add_in1  output  W  adder operand 1 (registered)
add_in2  output  W  adder operand 2 (registered)
add_round_m  output  3  adder rounding mode (registered)
add_out  input  W  adder result
add_ov, add_un, add_inv, add_inexact  input  1 each  adder exception outputs
rsp_valid  output  1  FIFO head valid
rsp_ready  input  1  pop when rsp_valid&&rsp_ready
rsp_data  output  W  FIFO head result
rsp_flags  output  5  FIFO head flags {NV,DZ,OF,UF,NX}; DZ always 0
fflags  output  5  sticky OR of retired flags, same bit order
fflags_clr  input  1  synchronous clear of fflags
busy  output  1  state != IDLE or rsp_valid

Behaviour:
- Reset (rst=1, asynchronous): state IDLE, wait counter 0, FIFO empty, rsp_valid 0, rsp_data/rsp_flags 0, add_in1/add_in2/add_round_m 0, fflags 0, busy 0.
- At integration, the adder's active-low reset is driven with ~rst. An operation in flight when rst asserts is discarded and produces no response.
- FSM states:
  - IDLE -> WAIT on accept.
  - WAIT: counter increments each cycle; moves to CAPT at the edge where the counter reaches LAT-1.
  - CAPT: on the edge, pushes {add_out, flags} into the FIFO. Goes to WAIT if a new request is accepted on the same edge, else IDLE.
- req_ready = (IDLE && fifo_cnt<DEPTH) || (CAPT && fifo_cnt<DEPTH-1). Pops are not credited in the same cycle. Combinational from state/count only; never depends on req_valid.
- On accept: add_in1<=req_a, add_in2<=req_b, add_round_m<=req_rm, counter<=0. These registers change only on accept and hold between accepts.
- Timing: accept at edge k -> adder output valid during the cycle after edge k+LAT -> FIFO push at edge k+LAT+1. rsp_valid rises after that edge (LAT+1 cycles when the FIFO is empty). Maximum throughput is one op per LAT+1 cycles.
- Accept in CAPT: the push captures the old result on the same edge that the operands change. This is legal because the adder output register updates on that edge.
- Push flags = {add_inv, 1'b0, add_ov, add_un, add_inexact}. The adder's done output is ignored.
- FIFO: circular with wrapping pointers. Simultaneous push and pop keeps the count. A push into a full FIFO cannot occur by construction (assertion in bench). rsp_data/rsp_flags are stable while rsp_valid && !rsp_ready.
- fflags update at the push edge: fflags <= (fflags_clr ? 0 : fflags) | push_flags. A clear and a push in the same cycle leave only the new op's flags. fflags_clr without a push zeroes fflags. Pops do not affect fflags.
- busy=0 only in IDLE with an empty FIFO.

Test Plan:
- Accept req_a=0x3F800000, req_b=0x40000000, rm=RNe, rsp_ready=1 -> add_in1/add_in2 stable 3 cycles; rsp_valid exactly LAT+1=3 cycles after accept; rsp_data=0x40400000, rsp_flags=00000.
- req_a=0x7F800000, req_b=0xFF800000 -> rsp_data=quiet NaN, rsp_flags=10000; then 1.0+1.0 -> rsp_flags=00000, fflags remains 10000.
- req_a=0x3F800000, req_b=0x30800000, RNe -> rsp_data=0x3F800000, rsp_flags=00001. Assert fflags_clr on the push cycle -> fflags=00001.
- rsp_ready=0, req_valid held high -> 4 ops accepted then req_ready=0. The second accept occurs at the CAPT edge, 3 cycles after the first. One pop -> req_ready returns next IDLE cycle; FIFO data pops in order.
- Assert rst during WAIT -> outputs reset immediately, no rsp_valid afterwards. After release, a normal op completes in 3 cycles.
- Simultaneous push and pop with fifo_cnt=2 -> count stays 2; the pointers wrap correctly after 8+ ops.
